// File: rtl/ghost_hit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ghost_hit_ctrl
// Brief    : Yoshi/ghost collision detection, lives, invulnerability window,
//            game-over and score-driven ghost speed offset.
// Revision : 1.0 - initial release
// ============================================================================
module ghost_hit_ctrl #(
    parameter int T_W           = 16,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_CYCLES = 100000000,
    parameter int SPEED_STEP    = 50000,
    parameter int SPEED_MAX     = 4000000,
    parameter int BLINK_BIT     = 22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  y_x,
    input  logic [9:0]  y_y,
    input  logic [9:0]  g_t_x,
    input  logic [9:0]  g_t_y,
    input  logic [9:0]  g_b_x,
    input  logic [9:0]  g_b_y,
    input  logic        score_tick,
    output logic        hit,
    output logic [1:0]  lives,
    output logic        invuln,
    output logic        blink,
    output logic        game_over,
    output logic [25:0] speed_offset
);

    // Timer must hold INVULN_CYCLES-1 and also expose BLINK_BIT.
    localparam int TMR_W = ($clog2(INVULN_CYCLES) > BLINK_BIT) ?
                           $clog2(INVULN_CYCLES) : BLINK_BIT + 1;
    localparam logic [TMR_W-1:0] C_TMR_LOAD = TMR_W'(INVULN_CYCLES - 1);
    localparam logic [10:0]      C_TW       = 11'(T_W);
    localparam logic [26:0]      C_STEP     = 27'(SPEED_STEP);
    localparam logic [25:0]      C_MAX      = 26'(SPEED_MAX);

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_INVULN = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               hit_q, hit_d;
    logic               invuln_q, invuln_d;
    logic               game_over_q, game_over_d;
    logic [25:0]        speed_q, speed_d;
    logic               ovl_q, ovl_d;
    logic [26:0]        speed_sum;

    // Zero-extended to 11 bits so positions near 1023 plus T_W never wrap.
    function automatic logic box_overlap(input logic [9:0] gx, input logic [9:0] gy,
                                         input logic [9:0] yx, input logic [9:0] yy);
        logic [10:0] gx11, gy11, yx11, yy11;
        gx11 = {1'b0, gx};
        gy11 = {1'b0, gy};
        yx11 = {1'b0, yx};
        yy11 = {1'b0, yy};
        return (gx11 < yx11 + C_TW) && (yx11 < gx11 + C_TW) &&
               (gy11 < yy11 + C_TW) && (yy11 < gy11 + C_TW);
    endfunction

    always_comb begin
        ovl_d       = box_overlap(g_t_x, g_t_y, y_x, y_y) |
                      box_overlap(g_b_x, g_b_y, y_x, y_y);
        state_d     = state_q;
        lives_d     = lives_q;
        timer_d     = timer_q;
        hit_d       = 1'b0;
        invuln_d    = invuln_q;
        game_over_d = game_over_q;
        speed_d     = speed_q;
        speed_sum   = {1'b0, speed_q} + C_STEP;

        case (state_q)
            ST_PLAY: begin
                if (ovl_q) begin
                    hit_d   = 1'b1;
                    lives_d = lives_q - 2'd1;
                    if (lives_q == 2'd1) begin
                        state_d     = ST_OVER;
                        game_over_d = 1'b1;
                    end else begin
                        state_d  = ST_INVULN;
                        invuln_d = 1'b1;
                        timer_d  = C_TMR_LOAD;
                    end
                end
            end
            ST_INVULN: begin
                if (timer_q == '0) begin
                    state_d  = ST_PLAY;
                    invuln_d = 1'b0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_OVER: begin
                lives_d = 2'd0;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase

        // Ticks still count on the cycle a final hit moves us into OVER.
        if (score_tick && (state_q != ST_OVER)) begin
            speed_d = (speed_sum > {1'b0, C_MAX}) ? C_MAX : speed_sum[25:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_PLAY;
            lives_q     <= 2'(LIVES_INIT);
            timer_q     <= '0;
            hit_q       <= 1'b0;
            invuln_q    <= 1'b0;
            game_over_q <= 1'b0;
            speed_q     <= '0;
            ovl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            timer_q     <= timer_d;
            hit_q       <= hit_d;
            invuln_q    <= invuln_d;
            game_over_q <= game_over_d;
            speed_q     <= speed_d;
            ovl_q       <= ovl_d;
        end
    end

    assign hit          = hit_q;
    assign lives        = lives_q;
    assign invuln       = invuln_q;
    assign blink        = invuln_q & timer_q[BLINK_BIT];
    assign game_over    = game_over_q;
    assign speed_offset = speed_q;

endmodule
`default_nettype wire

// File: tb/tb_ghost_hit_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_hit_ctrl
// Brief    : Randomized + directed self-checking bench for ghost_hit_ctrl
//            against a behavioural game-rule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghost_hit_ctrl;

    localparam int N     = 8;
    localparam int BB    = 1;
    localparam int STEP  = 50000;
    localparam int SMAX  = 4000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  y_x = 10'd100, y_y = 10'd100;
    logic [9:0]  g_t_x = 10'd300, g_t_y = 10'd300;
    logic [9:0]  g_b_x = 10'd500, g_b_y = 10'd50;
    logic        score_tick = 1'b0;
    logic        hit, invuln, blink, game_over;
    logic [1:0]  lives;
    logic [25:0] speed_offset;

    int n_tests = 0;
    int n_fail  = 0;
    int hit_cnt = 0;

    // Game-rule model: inv_left counts invulnerable cycles still to come.
    int m_lives, m_inv_left, m_speed;
    bit m_over, m_hit, m_ovl;

    ghost_hit_ctrl #(
        .T_W(16), .LIVES_INIT(3), .INVULN_CYCLES(N),
        .SPEED_STEP(STEP), .SPEED_MAX(SMAX), .BLINK_BIT(BB)
    ) dut (
        .clk(clk), .reset(reset),
        .y_x(y_x), .y_y(y_y),
        .g_t_x(g_t_x), .g_t_y(g_t_y),
        .g_b_x(g_b_x), .g_b_y(g_b_y),
        .score_tick(score_tick),
        .hit(hit), .lives(lives), .invuln(invuln), .blink(blink),
        .game_over(game_over), .speed_offset(speed_offset)
    );

    always #5 clk = ~clk;

    function automatic bit boxes_touch(int gx, int gy, int yx, int yy);
        return (gx < yx + 16) && (yx < gx + 16) && (gy < yy + 16) && (yy < gy + 16);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit ovl_now;
        ovl_now = boxes_touch(g_t_x, g_t_y, y_x, y_y) || boxes_touch(g_b_x, g_b_y, y_x, y_y);
        if (reset) begin
            m_lives = 3; m_inv_left = 0; m_over = 0; m_hit = 0; m_speed = 0; m_ovl = 0;
        end else begin
            m_hit = 0;
            if (score_tick && !m_over)
                m_speed = (m_speed + STEP > SMAX) ? SMAX : m_speed + STEP;
            if (m_over) begin
            end else if (m_inv_left > 0) begin
                m_inv_left--;
            end else if (m_ovl) begin
                m_hit = 1;
                m_lives--;
                if (m_lives == 0) m_over = 1;
                else m_inv_left = N;
            end
            m_ovl = ovl_now;
        end
    endtask

    task automatic step();
        int exp_blink;
        @(posedge clk);
        model_edge();
        #1;
        exp_blink = (m_inv_left > 0) ? (((m_inv_left - 1) >> BB) & 1) : 0;
        check("hit", hit, m_hit);
        check("lives", lives, m_lives);
        check("invuln", invuln, (m_inv_left > 0));
        check("blink", blink, exp_blink);
        check("game_over", game_over, m_over);
        check("speed_offset", speed_offset, m_speed);
        if (hit === 1'b1) hit_cnt++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic ghosts_away();
        g_t_x = 10'd300; g_t_y = 10'd300; g_b_x = 10'd500; g_b_y = 10'd50;
    endtask

    task automatic do_reset();
        reset = 1'b1; score_tick = 1'b0;
        steps(2);
        reset = 1'b0;
    endtask

    initial begin
        // Reset values held with no overlap
        y_x = 10'd100; y_y = 10'd100;
        ghosts_away();
        do_reset();
        steps(50);
        check("reset_lives", lives, 3);

        // Single hit, then the invulnerability window runs out
        g_t_x = 10'd110; g_t_y = 10'd105;
        hit_cnt = 0;
        step();
        ghosts_away();
        steps(12);
        check("single_hit_count", hit_cnt, 1);
        check("single_hit_lives", lives, 2);

        // Edge-adjacent is not a collision; one pixel closer is
        g_t_x = 10'd116; g_t_y = 10'd100;
        hit_cnt = 0;
        steps(4);
        check("adjacent_no_hit", hit_cnt, 0);
        g_t_x = 10'd115;
        step();
        ghosts_away();
        steps(12);
        check("boundary_hit_count", hit_cnt, 1);
        check("boundary_lives", lives, 1);

        // Both ghosts in the same cycle count once
        g_t_x = 10'd105; g_t_y = 10'd95;
        g_b_x = 10'd95;  g_b_y = 10'd110;
        hit_cnt = 0;
        step();
        ghosts_away();
        steps(12);
        check("dual_hit_count", hit_cnt, 1);
        check("dual_game_over", game_over, 1);

        // Persistent overlap runs lives down to game over
        do_reset();
        g_t_x = 10'd100; g_t_y = 10'd100;
        hit_cnt = 0;
        steps(40);
        check("persist_hits", hit_cnt, 3);
        check("persist_over", game_over, 1);
        ghosts_away();

        // Speed saturation
        do_reset();
        score_tick = 1'b1;
        steps(85);
        score_tick = 1'b0;
        step();
        check("speed_saturated", speed_offset, SMAX);

        // Tick coinciding with a hit, then ticks while over
        do_reset();
        score_tick = 1'b1;
        steps(3);
        score_tick = 1'b0;
        g_t_x = 10'd100; g_t_y = 10'd100;
        step();
        score_tick = 1'b1;
        step();
        score_tick = 1'b0;
        check("tick_with_hit_hit", hit, 1);
        check("tick_with_hit_speed", speed_offset, 4 * STEP);
        steps(30);
        score_tick = 1'b1;
        steps(10);
        score_tick = 1'b0;
        check("over_speed_hold", speed_offset, 4 * STEP);
        ghosts_away();

        // Reset in the middle of invulnerability
        do_reset();
        score_tick = 1'b1;
        g_t_x = 10'd100; g_t_y = 10'd100;
        step();
        score_tick = 1'b0;
        ghosts_away();
        steps(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_lives", lives, 3);
        check("midreset_invuln", invuln, 0);
        check("midreset_speed", speed_offset, 0);

        // Randomized play, ghosts biased to hover near Yoshi
        for (int i = 0; i < 3000; i++) begin
            int yx, yy;
            yx = $urandom_range(1023, 0);
            yy = $urandom_range(1023, 0);
            y_x = 10'(yx); y_y = 10'(yy);
            if ($urandom_range(1, 0) == 1) begin
                g_t_x = 10'(yx + $urandom_range(40, 0) - 20);
                g_t_y = 10'(yy + $urandom_range(40, 0) - 20);
            end else begin
                g_t_x = 10'($urandom_range(1023, 0));
                g_t_y = 10'($urandom_range(1023, 0));
            end
            g_b_x = 10'(yx + $urandom_range(36, 0) - 18);
            g_b_y = 10'(yy + $urandom_range(36, 0) - 18);
            score_tick = ($urandom_range(3, 0) == 0);
            reset = ($urandom_range(199, 0) == 0);
            step();
        end
        reset = 1'b0;
        score_tick = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
